keypad_scan4x4: RTL and testbench

- Scanned-input counterpart to the scanned 7-segment output driver.
- Drives one-cold rows of a 4x4 matrix keypad and samples the active-low columns.
- Debounces each press and encodes it to a hex nibble (0x0–0xF).
- Shifts accepted nibbles into a 32-bit register that the CPU reads over the same cs-style peripheral strobe. The result mirrors the display's 8-nibble format, so echo-to-display is a direct copy.

---
 rtl/keypad_scan4x4_if.sv | 18 +
 rtl/keypad_scan4x4.sv | 196 +++++++++++++++++++
 tb/tb_keypad_scan4x4.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan4x4_if.sv
// CPU-side bus of the 4x4 keypad scanner: read-acknowledge strobe plus key, history and valid.
// With KEYPAD_OVERRUN_EN defined the bus also carries o_overrun.
`timescale 1ns/1ps
interface keypad_scan4x4_if;
  logic        cs;
  logic [3:0]  o_key;
  logic [31:0] o_data;
  logic        o_valid;
`ifdef KEYPAD_OVERRUN_EN
  logic        o_overrun;

  modport master (output cs, input o_key, input o_data, input o_valid, input o_overrun);
  modport slave  (input cs, output o_key, output o_data, output o_valid, output o_overrun);
`else
  modport master (output cs, input o_key, input o_data, input o_valid);
  modport slave  (input cs, output o_key, output o_data, output o_valid);
`endif
endinterface

// File: rtl/keypad_scan4x4.sv
// 4x4 matrix keypad scanner: one-cold row drive, debounced column sampling, hex encoding
// and a 32-bit nibble history. Optional overrun flag enabled by defining KEYPAD_OVERRUN_EN.
`timescale 1ns/1ps
module keypad_scan4x4 #(
  parameter int SCAN_DIV_W     = 15,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scan4x4_if.slave   bus,
  input  logic [3:0]        i_col,
  output logic [3:0]        o_row
);

  localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } state_t;

  logic [3:0]            col_m;
  logic [3:0]            col_s;
  logic [SCAN_DIV_W-1:0] div_cnt;
  logic                  tick;

  state_t                state;
  state_t                state_nxt;
  logic [1:0]            row_idx;
  logic [1:0]            row_idx_nxt;
  logic [3:0]            db_cnt;
  logic [3:0]            db_cnt_nxt;
  logic [3:0]            db_inc;
  logic [1:0]            lat_col;
  logic [1:0]            lat_col_nxt;
  logic [1:0]            win_col;
  logic                  col_any;
  logic                  commit;
  logic [3:0]            commit_key;

  logic [3:0]            key_q;
  logic [31:0]           data_q;
  logic                  valid_q;

  // Columns are asynchronous to clk; only col_s is ever used for decisions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_m <= i_col;
      col_s <= col_m;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + SCAN_DIV_W'(1);
    end
  end

  assign tick = &div_cnt;

  // Lowest-index low column wins when several keys share the driven row.
  always_comb begin
    col_any = (col_s != 4'hF);
    win_col = 2'd3;
    if (!col_s[0]) begin
      win_col = 2'd0;
    end else if (!col_s[1]) begin
      win_col = 2'd1;
    end else if (!col_s[2]) begin
      win_col = 2'd2;
    end
  end

  assign db_inc = db_cnt + 4'd1;

  always_comb begin
    state_nxt   = state;
    row_idx_nxt = row_idx;
    db_cnt_nxt  = db_cnt;
    lat_col_nxt = lat_col;
    commit      = 1'b0;
    commit_key  = {row_idx, lat_col};
    if (tick) begin
      case (state)
        SCAN: begin
          if (!col_any) begin
            row_idx_nxt = row_idx + 2'd1;
          end else begin
            lat_col_nxt = win_col;
            commit_key  = {row_idx, win_col};
            if (DB_LIMIT == 4'd1) begin
              commit     = 1'b1;
              db_cnt_nxt = 4'd0;
              state_nxt  = HOLD;
            end else begin
              db_cnt_nxt = 4'd1;
              state_nxt  = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (col_any && (win_col == lat_col)) begin
            db_cnt_nxt = db_inc;
            if (db_inc == DB_LIMIT) begin
              commit     = 1'b1;
              db_cnt_nxt = 4'd0;
              state_nxt  = HOLD;
            end
          end else begin
            db_cnt_nxt  = 4'd0;
            row_idx_nxt = row_idx + 2'd1;
            state_nxt   = SCAN;
          end
        end
        HOLD: begin
          // Any low column restarts the release count, so chatter cannot end the hold early.
          if (col_any) begin
            db_cnt_nxt = 4'd0;
          end else if (db_inc == DB_LIMIT) begin
            db_cnt_nxt  = 4'd0;
            row_idx_nxt = row_idx + 2'd1;
            state_nxt   = SCAN;
          end else begin
            db_cnt_nxt = db_inc;
          end
        end
        default: begin
          db_cnt_nxt = 4'd0;
          state_nxt  = SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= SCAN;
      row_idx <= 2'd0;
      db_cnt  <= 4'd0;
      lat_col <= 2'd0;
      o_row   <= 4'b1110;
    end else begin
      state   <= state_nxt;
      row_idx <= row_idx_nxt;
      db_cnt  <= db_cnt_nxt;
      lat_col <= lat_col_nxt;
      o_row   <= ~(4'b0001 << row_idx_nxt);
    end
  end

  // A commit in the same cycle as cs wins, keeping valid set for the new key.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q   <= 4'd0;
      data_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      if (commit) begin
        key_q   <= commit_key;
        data_q  <= {data_q[27:0], commit_key};
        valid_q <= 1'b1;
      end else if (bus.cs) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_key   = key_q;
  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;

`ifdef KEYPAD_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else begin
      if (commit && valid_q && !bus.cs) begin
        overrun_q <= 1'b1;
      end else if (bus.cs) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.o_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_keypad_scan4x4.sv
// Self-checking bench for keypad_scan4x4: a physical keypad model drives the columns and a
// tick-level reference model predicts row, key, history, valid (and overrun when enabled).
`timescale 1ns/1ps
module tb_keypad_scan4x4;

  localparam int SCAN_DIV_W     = 4;
  localparam int DEBOUNCE_SCANS = 4;
  localparam int TICK_CLKS      = 1 << SCAN_DIV_W;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  i_col;
  logic [3:0]  o_row;
  logic [15:0] pressed;

  keypad_scan4x4_if bus ();

  keypad_scan4x4 #(
    .SCAN_DIV_W     (SCAN_DIV_W),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .i_col (i_col),
    .o_row (o_row)
  );

  always #5 clk = ~clk;

  // Physical matrix: a held key pulls its column low only while its row is driven low.
  always_comb begin
    i_col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !o_row[r]) begin
          i_col[c] = 1'b0;
        end
      end
    end
  end

  int          total;
  int          bad;
  int          exp_row;
  logic [3:0]  exp_key;
  logic [31:0] exp_data;
  logic        exp_valid;
  logic        exp_ovr;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [3:0] row_pat(input int r);
    logic [3:0] p;
    p    = 4'hF;
    p[r] = 1'b0;
    return p;
  endfunction

  function automatic logic [3:0] winner(input logic [15:0] m, input int r);
    logic [3:0] w;
    w = 4'd0;
    for (int c = 3; c >= 0; c--) begin
      if (m[r*4+c]) w = 4'(r*4 + c);
    end
    return w;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check_output({tag, "/row"},   32'(o_row),       32'(row_pat(exp_row)));
    check_output({tag, "/valid"}, 32'(bus.o_valid), 32'(exp_valid));
    check_output({tag, "/key"},   32'(bus.o_key),   32'(exp_key));
    check_output({tag, "/data"},  bus.o_data,       exp_data);
`ifdef KEYPAD_OVERRUN_EN
    check_output({tag, "/ovr"},   32'(bus.o_overrun), 32'(exp_ovr));
`endif
  endtask

  task automatic model_reset();
    exp_row   = 0;
    exp_key   = 4'd0;
    exp_data  = 32'd0;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  // One scan period; cs_mode 1 pulses cs on the first clk, 2 pulses cs on the tick edge itself.
  task automatic apply_tick(input int cs_mode);
    for (int i = 0; i < TICK_CLKS; i++) begin
      bus.cs = ((cs_mode == 1) && (i == 0)) || ((cs_mode == 2) && (i == TICK_CLKS - 1));
      @(posedge clk);
      @(negedge clk);
    end
    bus.cs = 1'b0;
  endtask

  task automatic apply_ack();
    apply_tick(1);
    exp_row   = (exp_row + 1) % 4;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    check_all("ack");
  endtask

  task automatic seek_row(input int r);
    for (int g = 0; g < 4 && exp_row != r; g++) begin
      apply_tick(0);
      exp_row = (exp_row + 1) % 4;
      check_all("seek");
    end
  endtask

  task automatic do_reset();
    pressed = 16'd0;
    bus.cs  = 1'b0;
    reset   = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic apply_stimulus(input int r, input logic [15:0] mask, input int n_ticks,
                                input int commit_cs, input bit do_release);
    logic [3:0] k;
    k = winner(mask, r);
    seek_row(r);
    pressed = mask;
    for (int t = 1; t <= n_ticks; t++) begin
      apply_tick((t == DEBOUNCE_SCANS) ? commit_cs : 0);
      if (t == DEBOUNCE_SCANS) begin
        if (commit_cs == 2) exp_ovr = 1'b0;
        else if (exp_valid) exp_ovr = 1'b1;
        exp_key   = k;
        exp_data  = {exp_data[27:0], k};
        exp_valid = 1'b1;
      end
      check_all("press");
    end
    if (do_release) begin
      pressed = 16'd0;
      if (n_ticks >= DEBOUNCE_SCANS) begin
        for (int t = 1; t <= DEBOUNCE_SCANS; t++) begin
          apply_tick(0);
          if (t == DEBOUNCE_SCANS) exp_row = (exp_row + 1) % 4;
          check_all("release");
        end
      end else begin
        apply_tick(0);
        exp_row = (exp_row + 1) % 4;
        check_all("abandon");
      end
    end
  endtask

  initial begin
    int r;
    int n;
    logic [15:0] m;
    total   = 0;
    bad     = 0;
    reset   = 1'b0;
    bus.cs  = 1'b0;
    pressed = 16'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("por");
    reset = 1'b1;

    for (int i = 0; i < 4; i++) begin
      apply_tick(0);
      exp_row = (exp_row + 1) % 4;
      check_all("idle");
    end

    apply_stimulus(1, 16'(1 << 6), 6, 0, 1'b1);
    check_output("k6_data", bus.o_data, 32'h6);
    check_output("k6_key", 32'(bus.o_key), 32'h6);
    apply_ack();
    check_output("k6_data_after_cs", bus.o_data, 32'h6);

    apply_stimulus(1, 16'(1 << 6), 2, 0, 1'b1);
    check_output("bounce_valid", 32'(bus.o_valid), 32'h0);

    // Winning column changes mid-debounce: the press is abandoned.
    seek_row(2);
    pressed = 16'(1 << 10);
    for (int t = 0; t < 2; t++) begin
      apply_tick(0);
      check_all("switch");
    end
    pressed = 16'(1 << 8);
    apply_tick(0);
    exp_row = (exp_row + 1) % 4;
    check_all("switch_abandon");
    pressed = 16'd0;

    do_reset();
    for (int k = 1; k <= 9; k++) begin
      apply_stimulus(k / 4, 16'(1 << k), DEBOUNCE_SCANS, 0, 1'b1);
      apply_ack();
    end
    check_output("history", bus.o_data, 32'h23456789);

    apply_stimulus(3, 16'h8000, DEBOUNCE_SCANS + 1, 2, 1'b1);
    check_output("cs_commit_valid", 32'(bus.o_valid), 32'h1);
    apply_ack();

    for (int it = 0; it < 24; it++) begin
      r = int'($urandom_range(0, 3));
      m = 16'(1 << (r*4 + int'($urandom_range(0, 3))));
      if ($urandom_range(0, 3) == 0) m = m | 16'(1 << (r*4 + int'($urandom_range(0, 3))));
      if ($urandom_range(0, 2) == 0) n = int'($urandom_range(1, DEBOUNCE_SCANS - 1));
      else n = int'($urandom_range(DEBOUNCE_SCANS, DEBOUNCE_SCANS + 3));
      apply_stimulus(r, m, n, ($urandom_range(0, 3) == 0) ? 2 : 0, 1'b1);
      if ($urandom_range(0, 1) == 1) apply_ack();
    end

    apply_stimulus(1, 16'(1 << 5), DEBOUNCE_SCANS + 1, 0, 1'b0);
    do_reset();
    check_output("midhold_data", bus.o_data, 32'h0);
    check_output("midhold_row", 32'(o_row), 32'hE);

`ifdef KEYPAD_OVERRUN_EN
    do_reset();
    apply_stimulus(2, 16'(1 << 10), DEBOUNCE_SCANS, 0, 1'b1);
    apply_stimulus(2, 16'(1 << 11), DEBOUNCE_SCANS, 0, 1'b1);
    check_output("ovr_set", 32'(bus.o_overrun), 32'h1);
    check_output("ovr_data", bus.o_data, 32'hAB);
    apply_ack();
    check_output("ovr_clear", 32'(bus.o_overrun), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
